// File: rtl/l2_cache_assoc.sv
// N-way, S-set write-back/write-allocate L2 cache with true-LRU ages and an IDLE/CHECK/WB/FETCH miss controller.
// Optional hit/miss performance counters are built when L2_PERF_CNT_EN is defined.
module l2_cache_assoc #(
  parameter int NUM_WAYS = 8,
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_byte_enable,
  input  logic [255:0] mem_wdata,
  output logic [255:0] mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int TAG_W = 27 - IDX_W;

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, WB = 2'd2, FETCH = 2'd3} state_e;

  state_e state_q, state_d;
  logic [26:0] line_q, line_d;
  logic write_q, write_d, missed_q, missed_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [NUM_WAYS-1:0][NUM_SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [WAY_W-1:0] age_q [NUM_WAYS][NUM_SETS];
  logic [WAY_W-1:0] age_d [NUM_WAYS][NUM_SETS];
  logic [255:0] data_q [NUM_WAYS][NUM_SETS];
  logic [255:0] data_d [NUM_WAYS][NUM_SETS];
  logic [TAG_W-1:0] tag_q [NUM_WAYS][NUM_SETS];
  logic [TAG_W-1:0] tag_d [NUM_WAYS][NUM_SETS];

  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic hit_s, inv_s;
  logic [WAY_W-1:0] hit_way_s, inv_way_s, lru_way_s, victim_s;
  logic [255:0] merged_s;
  logic unused_s;

  assign idx_s = line_q[IDX_W-1:0];
  assign tag_s = line_q[26:IDX_W];
  assign unused_s = ^mem_address[4:0];

  // Lookup: loops run downwards so the lowest matching way wins.
  always_comb begin
    hit_s = 1'b0;
    hit_way_s = '0;
    inv_s = 1'b0;
    inv_way_s = '0;
    lru_way_s = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      hit_way_s = (valid_q[w][idx_s] && (tag_q[w][idx_s] == tag_s)) ? WAY_W'(w) : hit_way_s;
      hit_s = hit_s | (valid_q[w][idx_s] && (tag_q[w][idx_s] == tag_s));
      inv_way_s = !valid_q[w][idx_s] ? WAY_W'(w) : inv_way_s;
      inv_s = inv_s | !valid_q[w][idx_s];
      lru_way_s = (age_q[w][idx_s] == WAY_W'(NUM_WAYS - 1)) ? WAY_W'(w) : lru_way_s;
    end
    victim_s = inv_s ? inv_way_s : lru_way_s;
  end

  always_comb begin
    merged_s = data_q[hit_way_s][idx_s];
    for (int b = 0; b < 32; b++) begin
      merged_s[8*b +: 8] = mem_byte_enable[b] ? mem_wdata[8*b +: 8] : merged_s[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    line_d = line_q;
    write_d = write_q;
    missed_d = missed_q;
    victim_d = victim_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    age_d = age_q;
    data_d = data_q;
    tag_d = tag_q;
    mem_resp = 1'b0;
    mem_rdata = '0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d = CHECK;
          line_d = mem_address[31:5];
          write_d = mem_write;
          missed_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (hit_s) begin
          mem_resp = 1'b1;
          mem_rdata = data_q[hit_way_s][idx_s];
          if (write_q) begin
            data_d[hit_way_s][idx_s] = merged_s;
            dirty_d[hit_way_s][idx_s] = 1'b1;
          end else begin
            dirty_d[hit_way_s][idx_s] = dirty_q[hit_way_s][idx_s];
          end
          for (int w = 0; w < NUM_WAYS; w++) begin
            age_d[w][idx_s] = (age_q[w][idx_s] < age_q[hit_way_s][idx_s]) ?
                              age_q[w][idx_s] + WAY_W'(1) : age_q[w][idx_s];
          end
          age_d[hit_way_s][idx_s] = '0;
          state_d = IDLE;
        end else begin
          victim_d = victim_s;
          missed_d = 1'b1;
          // A clean miss starts the line fetch request already in this cycle.
          if (valid_q[victim_s][idx_s] && dirty_q[victim_s][idx_s]) begin
            state_d = WB;
          end else begin
            state_d = FETCH;
            pmem_read = 1'b1;
            pmem_address = {tag_s, idx_s, 5'b00000};
          end
        end
      end
      WB: begin
        pmem_write = 1'b1;
        pmem_address = {tag_q[victim_q][idx_s], idx_s, 5'b00000};
        pmem_wdata = data_q[victim_q][idx_s];
        if (pmem_resp) begin
          state_d = FETCH;
        end else begin
          state_d = WB;
        end
      end
      FETCH: begin
        pmem_read = 1'b1;
        pmem_address = {tag_s, idx_s, 5'b00000};
        if (pmem_resp) begin
          data_d[victim_q][idx_s] = pmem_rdata;
          tag_d[victim_q][idx_s] = tag_s;
          valid_d[victim_q][idx_s] = 1'b1;
          dirty_d[victim_q][idx_s] = 1'b0;
          state_d = CHECK;
        end else begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state, line status and LRU ages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      line_q <= '0;
      write_q <= 1'b0;
      missed_q <= 1'b0;
      victim_q <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          age_q[w][s] <= WAY_W'(w);
        end
      end
    end else begin
      state_q <= state_d;
      line_q <= line_d;
      write_q <= write_d;
      missed_q <= missed_d;
      victim_q <= victim_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      age_q <= age_d;
    end
  end

  // Line data and tags carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q <= tag_d;
  end

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d = hit_count_q;
    miss_count_d = miss_count_q;
    if (mem_resp && !missed_q) begin
      hit_count_d = hit_count_q + 32'd1;
    end else begin
      hit_count_d = hit_count_q;
    end
    if ((state_q == CHECK) && !hit_s) begin
      miss_count_d = miss_count_q + 32'd1;
    end else begin
      miss_count_d = miss_count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      hit_count_q <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_l2_cache_assoc.sv
// Scoreboard bench for l2_cache_assoc: a recency-list cache model predicts responses and pmem traffic;
// a responder plays physical memory and monitors pmem, a separate monitor checks every mem_resp.
module tb_l2_cache_assoc;
  localparam int NW = 8;
  localparam int NS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] mem_address = '0, mem_byte_enable = '0;
  logic [255:0] mem_wdata = '0, mem_rdata;
  logic mem_resp, pmem_read, pmem_write;
  logic [31:0] pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic pmem_resp;
`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  l2_cache_assoc #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
`ifdef L2_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } ptx_t;
  typedef struct { bit wr; bit hit; logic [255:0] rdata; int issue_cyc; } rsp_t;
  typedef struct { logic [26:0] line; logic [255:0] data; bit dirty; } ent_t;

  ptx_t pexp_q[$];
  rsp_t rexp_q[$];
  ent_t cache_q[$];               // most recently used first
  logic [255:0] ref_mem [logic [26:0]];
  logic [255:0] phys_mem [logic [26:0]];

  int checks = 0, failures = 0;
  int cyc = 0, last_presp_cyc = 0;
  int mdl_hits = 0, mdl_misses = 0;
  bit slow = 1'b0;
  logic [31:0] last_wb_addr = '1;
  logic [255:0] last_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] line_init(input logic [26:0] l);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = {5'(k), l} ^ 32'h5A3C_96E1;
    return r;
  endfunction

  task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Reference model: per-set recency order, LRU eviction, write-back of dirty victims.
  task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] be,
                              input logic [255:0] wd, output bit hit, output logic [255:0] rd);
    logic [26:0] l;
    int pos, cnt, lru;
    ent_t e, v;
    l = addr[31:5];
    pos = -1; cnt = 0; lru = -1;
    for (int i = 0; i < cache_q.size(); i++) begin
      if ((cache_q[i].line % NS) == (l % NS)) begin
        cnt++;
        lru = i;
        if (cache_q[i].line == l) pos = i;
      end
    end
    if (pos >= 0) begin
      hit = 1'b1;
      e = cache_q[pos];
      cache_q.delete(pos);
      mdl_hits++;
    end else begin
      hit = 1'b0;
      mdl_misses++;
      if (cnt == NW) begin
        v = cache_q[lru];
        cache_q.delete(lru);
        if (v.dirty) begin
          pexp_q.push_back('{1'b1, {v.line, 5'b00000}, v.data});
          ref_mem[v.line] = v.data;
        end
      end
      pexp_q.push_back('{1'b0, {l, 5'b00000}, 256'd0});
      e.line = l;
      e.data = ref_mem.exists(l) ? ref_mem[l] : line_init(l);
      e.dirty = 1'b0;
    end
    rd = e.data;
    if (wr) begin
      for (int b = 0; b < 32; b++) if (be[b]) e.data[8*b +: 8] = wd[8*b +: 8];
      e.dirty = 1'b1;
    end
    cache_q.push_front(e);
  endtask

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] be, input logic [255:0] wd);
    bit hit, got;
    logic [255:0] rd;
    model_access(wr, addr, be, wd, hit, rd);
    @(negedge clk); #2;
    rexp_q.push_back('{wr, hit, rd, cyc});
    mem_read = !wr; mem_write = wr; mem_address = addr; mem_byte_enable = be; mem_wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk); #2;
      got = mem_resp;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    if (!got) begin
      check(1'b0, "req_timeout", 256'(addr), 256'd0);
      finish_run();
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Physical memory responder; compares each new pmem request with the model's prediction.
  initial begin
    bit pend;
    int wcnt;
    ptx_t p;
    pend = 1'b0; wcnt = 0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else if (pmem_read || pmem_write) begin
        if (!pend) begin
          pend = 1'b1;
          wcnt = slow ? 8 : int'($urandom_range(1, 4));
          check(!(pmem_read && pmem_write), "pmem_rd_wr_both", {pmem_read, pmem_write}, 256'd0);
          if (pmem_write) last_wb_addr = pmem_address;
          if (pexp_q.size() == 0) begin
            check(1'b0, "unexpected_pmem", 256'(pmem_address), 256'd0);
          end else begin
            p = pexp_q.pop_front();
            check(pmem_write == p.wr, "pmem_kind", 256'(pmem_write), 256'(p.wr));
            check(pmem_address == p.addr, "pmem_addr", 256'(pmem_address), 256'(p.addr));
            if (p.wr) check(pmem_wdata == p.data, "wb_data", pmem_wdata, p.data);
          end
        end else begin
          wcnt--;
          if (wcnt == 0) begin
            if (pmem_write) phys_mem[pmem_address[31:5]] = pmem_wdata;
            else pmem_rdata = phys_mem.exists(pmem_address[31:5]) ? phys_mem[pmem_address[31:5]]
                                                                  : line_init(pmem_address[31:5]);
            pmem_resp = 1'b1;
            last_presp_cyc = cyc;
            pend = 1'b0;
          end
        end
      end
    end
  end

  // Response monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst && mem_resp) begin
        last_rdata = mem_rdata;
        if (rexp_q.size() == 0) begin
          check(1'b0, "unexpected_resp", mem_rdata, 256'd0);
        end else begin
          e = rexp_q.pop_front();
          if (!e.wr) check(mem_rdata == e.rdata, "rdata", mem_rdata, e.rdata);
          if (e.hit) check(cyc == e.issue_cyc + 1, "hit_latency", 256'(cyc - e.issue_cyc), 256'd1);
          else check(cyc == last_presp_cyc + 1, "miss_latency", 256'(cyc), 256'(last_presp_cyc + 1));
        end
      end
    end
  end

  initial begin
    #500000;
    check(1'b0, "watchdog", 256'(cyc), 256'd0);
    finish_run();
  end

  initial begin
    logic [255:0] wd, exp_line;
    logic [23:0] tg;
    bit seen;
    repeat (3) @(negedge clk);
    check(mem_resp == 1'b0, "rst_mem_resp", 256'(mem_resp), 256'd0);
    check(pmem_read == 1'b0 && pmem_write == 1'b0, "rst_pmem_req", {pmem_read, pmem_write}, 256'd0);
    check(pmem_address == 32'd0, "rst_pmem_addr", 256'(pmem_address), 256'd0);
`ifdef L2_PERF_CNT_EN
    check(hit_count == 32'd0 && miss_count == 32'd0, "rst_counters", {hit_count, miss_count}, 256'd0);
`endif
    rst = 1'b0;

    // Miss then hit on 0x40, then a byte-masked write hit and read-back.
    do_req(1'b0, 32'h0000_0040, 32'h0, 256'd0);
    do_req(1'b0, 32'h0000_0040, 32'h0, 256'd0);
    wd = '0; wd[31:0] = 32'hDEAD_BEEF;
    do_req(1'b1, 32'h0000_0040, 32'h0000_000F, wd);
    do_req(1'b0, 32'h0000_0040, 32'h0, 256'd0);
    exp_line = line_init(27'h2);
    exp_line[31:0] = 32'hDEAD_BEEF;
    check(last_rdata == exp_line, "write_merge", last_rdata, exp_line);

    // Fill set 2 with dirty tags 1..7, re-touch tag 0, then tag 8 must evict tag 1.
    for (int t = 1; t < 8; t++) do_req(1'b1, (32'(t) << 8) | 32'h40, 32'hFFFF_FFFF, {8{32'(t)}});
    do_req(1'b0, 32'h0000_0040, 32'h0, 256'd0);
    last_wb_addr = '1;
    do_req(1'b0, 32'h0000_0840, 32'h0, 256'd0);
    check(last_wb_addr == 32'h0000_0140, "lru_victim_wb", 256'(last_wb_addr), 256'h140);

    // Reset in the middle of a clean miss.
    slow = 1'b1;
    pexp_q.push_back('{1'b0, 32'h0000_00A0, 256'd0});
    @(negedge clk); #2;
    mem_read = 1'b1; mem_address = 32'h0000_00A0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #2;
      seen = pmem_read;
    end
    check(seen, "rst_test_pmem_read", 256'(seen), 256'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check(pmem_read == 1'b0 && pmem_write == 1'b0, "rst_drops_pmem", {pmem_read, pmem_write}, 256'd0);
    mem_read = 1'b0;
    pexp_q.delete(); rexp_q.delete(); cache_q.delete();
    mdl_hits = 0; mdl_misses = 0;
    repeat (2) @(negedge clk);
`ifdef L2_PERF_CNT_EN
    check(hit_count == 32'd0 && miss_count == 32'd0, "rst_counters_mid", {hit_count, miss_count}, 256'd0);
`endif
    rst = 1'b0;
    slow = 1'b0;
    do_req(1'b0, 32'h0000_00A0, 32'h0, 256'd0);
    do_req(1'b0, 32'h0000_0040, 32'h0, 256'd0);

    // Randomised traffic over two sets and twelve tags, with occasional high addresses.
    for (int n = 0; n < 400; n++) begin
      tg = 24'($urandom_range(0, 11));
      if ($urandom_range(0, 5) == 0) tg = tg | 24'hFFFF00;
      for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
      do_req(1'($urandom_range(0, 1)), {tg, 3'($urandom_range(0, 1)), 5'($urandom_range(0, 31))},
             $urandom, wd);
    end

    repeat (3) @(negedge clk);
    check(pexp_q.size() == 0, "pmem_exp_drained", 256'(pexp_q.size()), 256'd0);
    check(rexp_q.size() == 0, "resp_exp_drained", 256'(rexp_q.size()), 256'd0);
`ifdef L2_PERF_CNT_EN
    check(hit_count == 32'(mdl_hits), "hit_count", 256'(hit_count), 256'(mdl_hits));
    check(miss_count == 32'(mdl_misses), "miss_count", 256'(miss_count), 256'(mdl_misses));
`endif
    finish_run();
  end
endmodule
